// File: rtl/disp_scan_pkg.sv
// Shared constants for the seven-segment scanner: active-low font,
// blank pattern and the select-width helper.
package disp_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // {g,f,e,d,c,b,a} active-low, entry 15 first
    localparam logic [15:0][6:0] SEG_FONT = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        return SEG_FONT[h];
    endfunction

    function automatic int sel_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/disp_scan_if.sv
// Application-side bundle of the display driver: digit data and controls in,
// anode/segment pins and scan status out.
interface disp_scan_if #(
    parameter int NDIG = 4,
    parameter int BR_W = 4
);
    localparam int SW = disp_pkg::sel_w(NDIG);

    logic [4*NDIG-1:0] digits;
    logic [NDIG-1:0]   dp_in;
    logic [NDIG-1:0]   blank;
    logic              lz_blank;
    logic [BR_W-1:0]   brightness;
    logic [NDIG-1:0]   an;
    logic [6:0]        seg;
    logic              dp;
    logic [SW-1:0]     sel;
    logic              frame_tick;

    modport master (
        output digits, dp_in, blank, lz_blank, brightness,
        input  an, seg, dp, sel, frame_tick
    );

    modport slave (
        input  digits, dp_in, blank, lz_blank, brightness,
        output an, seg, dp, sel, frame_tick
    );

endinterface

// File: rtl/disp_scan_seg7_decode.sv
// Combinational hex nibble to active-low segment pattern.
module seg7_decode
    import disp_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);
    assign seg = hex_to_seg(nib);
endmodule

// File: rtl/disp_scan.sv
// Multiplexed common-anode seven-segment scanner with frame-synchronous
// input shadows, leading-zero suppression, PWM brightness and dead time.
module disp_scan
    import disp_pkg::*;
#(
    parameter int NDIG  = 4,
    parameter int DIV_W = 20,
    parameter int BR_W  = 4
) (
    input  logic        Clk,
    input  logic        Reset_n,
    disp_scan_if.slave  bus
);
    localparam int              SW       = sel_w(NDIG);
    localparam logic [SW-1:0]   SEL_LAST = SW'(NDIG - 1);
    localparam logic [NDIG-1:0] ONE_HOT0 = NDIG'(1);

    logic [DIV_W-1:0]      slot_cnt;
    logic [SW-1:0]         sel;
    logic [NDIG-1:0][3:0]  sh_dig;
    logic [NDIG-1:0]       sh_dp;
    logic [NDIG-1:0]       sh_blank;
    logic                  sh_lz;
    logic [BR_W-1:0]       sh_br;

    logic [NDIG-1:0][6:0]  font;
    logic [NDIG:1]         hz;
    logic [NDIG-1:0]       lz_sup;
    logic [BR_W-1:0]       phase;
    logic                  slot_end, frame_start, lit;
    logic [NDIG-1:0]       an_d, an_q;
    logic [6:0]            seg_d, seg_q;
    logic                  dp_d, dp_q, tick_q;

    assign slot_end    = &slot_cnt;
    assign frame_start = (sel == '0) && (slot_cnt == '0);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            slot_cnt <= '0;
            sel      <= '0;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
            if (slot_end)
                sel <= (sel == SEL_LAST) ? '0 : sel + 1'b1;
        end
    end

    // Inputs are sampled only at frame start so a frame never mixes two values
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sh_dig   <= '0;
            sh_dp    <= '0;
            sh_blank <= '0;
            sh_lz    <= 1'b0;
            sh_br    <= '0;
        end else if (frame_start) begin
            sh_dig   <= bus.digits;
            sh_dp    <= bus.dp_in;
            sh_blank <= bus.blank;
            sh_lz    <= bus.lz_blank;
            sh_br    <= bus.brightness;
        end
    end

    for (genvar g = 0; g < NDIG; g++) begin : g_dec
        seg7_decode u_dec (.nib(sh_dig[g]), .seg(font[g]));
    end

    // hz[k]: digit k and every digit above it are zero
    always_comb begin
        hz       = '0;
        hz[NDIG] = 1'b1;
        for (int k = NDIG - 1; k >= 1; k--)
            hz[k] = hz[k+1] && (sh_dig[k] == 4'h0);
    end

    assign lz_sup = sh_lz ? {hz[NDIG-1:1], 1'b0} : '0;
    assign phase  = slot_cnt[DIV_W-1 -: BR_W];
    assign lit    = (slot_cnt != '0) && !sh_blank[sel] && !lz_sup[sel] &&
                    ((phase < sh_br) || (&sh_br));

    always_comb begin
        an_d  = '1;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        if (lit) begin
            an_d  = ~(ONE_HOT0 << sel);
            seg_d = font[sel];
            dp_d  = ~sh_dp[sel];
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            an_q   <= '1;
            seg_q  <= SEG_OFF;
            dp_q   <= 1'b1;
            tick_q <= 1'b0;
        end else begin
            an_q   <= an_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
            tick_q <= (sel == SEL_LAST) && slot_end;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.sel        = sel;
    assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_disp_scan.sv
// Scoreboard bench for disp_scan: per-frame expectations are queued by the
// stimulus and compared by a monitor that summarises each scanned frame.
module tb_disp_scan;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    logic rst3_n = 1'b0;
    always #5 Clk = ~Clk;

    disp_scan_if #(.NDIG(4), .BR_W(2)) bus ();
    disp_scan_if #(.NDIG(3), .BR_W(2)) bus3 ();

    disp_scan #(.NDIG(4), .DIV_W(4), .BR_W(2)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .bus(bus.slave)
    );
    disp_scan #(.NDIG(3), .DIV_W(4), .BR_W(2)) dut3 (
        .Clk(Clk), .Reset_n(rst3_n), .bus(bus3.slave)
    );

    typedef struct packed {
        logic [7:0]      id;
        logic [3:0][4:0] lit;
        logic [3:0][6:0] seg;
        logic [3:0][4:0] dpn;
    } frame_t;

    frame_t sb[$];
    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int got, input int want);
        n_chk++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, got, want);
        end
    endtask

    task automatic set_in(input logic [15:0] d, input logic [3:0] dpi,
                          input logic [3:0] blk, input logic lz, input logic [1:0] br);
        bus.digits = d; bus.dp_in = dpi; bus.blank = blk;
        bus.lz_blank = lz; bus.brightness = br;
    endtask

    task automatic expect_frame(input logic [7:0] id, input logic [19:0] l,
                                input logic [27:0] s, input logic [19:0] p);
        frame_t e;
        e.id = id; e.lit = l; e.seg = s; e.dpn = p;
        sb.push_back(e);
    endtask

    task automatic wait_tick(input string nm);
        bit got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge Clk);
            got = bus.frame_tick;
        end
        chk({nm, " tick seen"}, int'(got), 1);
    endtask

    task automatic wait_sel(input int v);
        bit got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge Clk);
            got = (int'(bus.sel) == v);
        end
        chk($sformatf("sel reaches %0d", v), int'(got), 1);
    endtask

    // Monitor: summarise one frame (from tick to tick) and compare with the queue
    int            m_cnt;
    int            m_bad;
    bit            m_first;
    int            m_lit[4];
    int            m_dpn[4];
    logic [6:0]    m_seg[4];

    task automatic mon_clear();
        m_cnt = 0; m_bad = 0;
        for (int k = 0; k < 4; k++) begin
            m_lit[k] = 0; m_dpn[k] = 0; m_seg[k] = 7'h7F;
        end
    endtask

    initial begin
        int zeros;
        frame_t e;
        mon_clear();
        m_first = 1'b1;
        forever begin
            @(negedge Clk);
            if (!Reset_n) begin
                mon_clear();
                m_first = 1'b1;
            end else begin
                m_cnt++;
                zeros = 0;
                for (int k = 0; k < 4; k++) zeros += int'(!bus.an[k]);
                if (zeros == 0) begin
                    if (bus.seg != 7'h7F || bus.dp != 1'b1) m_bad++;
                end else if (zeros != 1) begin
                    m_bad++;
                end else begin
                    for (int k = 0; k < 4; k++) if (!bus.an[k]) begin
                        m_lit[k]++;
                        if (!bus.dp) m_dpn[k]++;
                        if (m_lit[k] == 1) m_seg[k] = bus.seg;
                        else if (bus.seg != m_seg[k]) m_bad++;
                    end
                end
                if (bus.frame_tick) begin
                    if (sb.size() == 0) begin
                        chk("unexpected frame", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        for (int k = 0; k < 4; k++) begin
                            chk($sformatf("f%0d lit[%0d]", e.id, k), m_lit[k], int'(e.lit[k]));
                            chk($sformatf("f%0d seg[%0d]", e.id, k), int'(m_seg[k]), int'(e.seg[k]));
                            chk($sformatf("f%0d dp[%0d]", e.id, k), m_dpn[k], int'(e.dpn[k]));
                        end
                        chk($sformatf("f%0d glitches", e.id), m_bad, 0);
                        if (!m_first) chk($sformatf("f%0d length", e.id), m_cnt, 64);
                    end
                    mon_clear();
                    m_first = 1'b0;
                end
            end
        end
    end

    task automatic check3();
        bit got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge Clk);
            got = bus3.frame_tick;
        end
        chk("n3 first tick", int'(got), 1);
        for (int s = 1; s <= 4; s++) begin
            repeat (16) @(negedge Clk);
            chk($sformatf("n3 sel step %0d", s), int'(bus3.sel), s % 3);
            chk($sformatf("n3 tick step %0d", s), int'(bus3.frame_tick), (s == 3) ? 1 : 0);
        end
    endtask

    localparam logic [19:0] L15 = {5'd15, 5'd15, 5'd15, 5'd15};
    localparam logic [19:0] L7  = {5'd7, 5'd7, 5'd7, 5'd7};
    localparam logic [19:0] L3  = {5'd3, 5'd3, 5'd3, 5'd3};
    localparam logic [27:0] S1238 = {7'h79, 7'h24, 7'h30, 7'h00};
    localparam logic [27:0] SOFF  = {7'h7F, 7'h7F, 7'h7F, 7'h7F};

    task automatic run_main();
        wait_tick("f1");
        set_in(16'h1238, 4'b0100, 4'h0, 1'b0, 2'd1);
        expect_frame(2, L3, S1238, {5'd0, 5'd3, 5'd0, 5'd0});
        wait_tick("f2");
        set_in(16'hCAFE, 4'h0, 4'h0, 1'b0, 2'd2);
        expect_frame(3, L7, {7'h46, 7'h08, 7'h0E, 7'h06}, '0);
        wait_tick("f3");
        set_in(16'hCAFE, 4'hF, 4'h0, 1'b0, 2'd0);
        expect_frame(4, '0, SOFF, '0);
        wait_tick("f4");
        set_in(16'h0050, 4'h0, 4'h0, 1'b1, 2'd3);
        expect_frame(5, {5'd0, 5'd0, 5'd15, 5'd15}, {7'h7F, 7'h7F, 7'h12, 7'h40}, '0);
        wait_tick("f5");
        set_in(16'h0000, 4'h0, 4'h0, 1'b1, 2'd3);
        expect_frame(6, {5'd0, 5'd0, 5'd0, 5'd15}, {7'h7F, 7'h7F, 7'h7F, 7'h40}, '0);
        wait_tick("f6");
        set_in(16'h0000, 4'h0, 4'b0001, 1'b1, 2'd3);
        expect_frame(7, '0, SOFF, '0);
        wait_tick("f7");
        set_in(16'h0050, 4'h0, 4'h0, 1'b0, 2'd3);
        expect_frame(8, L15, {7'h40, 7'h40, 7'h12, 7'h40}, '0);
        wait_tick("f8");
        set_in(16'h4567, 4'h0, 4'h0, 1'b0, 2'd3);
        expect_frame(9, L15, {7'h19, 7'h12, 7'h02, 7'h78}, '0);
        wait_sel(1);
        set_in(16'h89AB, 4'hF, 4'hF, 1'b1, 2'd0);
        wait_tick("f9");
        set_in(16'h89AB, 4'h0, 4'h0, 1'b0, 2'd3);
        expect_frame(10, L15, {7'h00, 7'h10, 7'h08, 7'h03}, '0);
        wait_tick("f10");
        wait_sel(2);
        repeat (5) @(negedge Clk);
        chk("pre-reset an", int'(bus.an), 4'hB);
        #1 Reset_n = 1'b0;
        #1;
        chk("async rst an", int'(bus.an), 4'hF);
        chk("async rst seg", int'(bus.seg), 7'h7F);
        chk("async rst dp", int'(bus.dp), 1);
        chk("async rst sel", int'(bus.sel), 0);
        chk("async rst tick", int'(bus.frame_tick), 0);
        set_in(16'hDE01, 4'h0, 4'h0, 1'b0, 2'd3);
        expect_frame(11, L15, {7'h21, 7'h06, 7'h40, 7'h79}, '0);
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        wait_tick("f11");
    endtask

    initial begin
        set_in(16'h1238, 4'h0, 4'h0, 1'b0, 2'd3);
        bus3.digits = 12'h123; bus3.dp_in = '0; bus3.blank = '0;
        bus3.lz_blank = 1'b0; bus3.brightness = 2'd3;
        repeat (3) @(negedge Clk);
        chk("reset an", int'(bus.an), 4'hF);
        chk("reset seg", int'(bus.seg), 7'h7F);
        chk("reset dp", int'(bus.dp), 1);
        chk("reset sel", int'(bus.sel), 0);
        chk("reset tick", int'(bus.frame_tick), 0);
        expect_frame(1, L15, S1238, '0);
        Reset_n = 1'b1;
        rst3_n = 1'b1;
        fork
            run_main();
            check3();
        join
        repeat (2) @(negedge Clk);
        chk("scoreboard drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
